// File: rtl/status_flags.sv
// status_flags: 6502 processor status register P (N V - B D I Z C).
// Captures ALU flags, feeds C back as carry_in, formats P for stack pushes,
// evaluates branch conditions and qualifies NMI/IRQ at instruction boundaries.
module status_flags #(
    parameter logic [7:0] RESET_P  = 8'h04,
    parameter bit         NMI_SYNC = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       alu_carry,
    input  logic       alu_overflow,
    input  logic       alu_zero,
    input  logic       alu_sign,
    input  logic       upd_nz,
    input  logic       upd_c,
    input  logic       upd_v,
    input  logic [2:0] flag_op,
    input  logic       bit_load,
    input  logic       plp_load,
    input  logic [7:0] din,
    input  logic       brk_flag,
    input  logic       sync,
    input  logic [1:0] cond_sel,
    input  logic       cond_val,
    input  logic       nmi_n,
    input  logic       irq_n,
    input  logic       intr_ack,
    output logic       carry_in,
    output logic [7:0] p_out,
    output logic       branch_taken,
    output logic       int_pending,
    output logic       int_is_nmi
);

    localparam logic [2:0] OP_CLC = 3'd1;
    localparam logic [2:0] OP_SEC = 3'd2;
    localparam logic [2:0] OP_CLI = 3'd3;
    localparam logic [2:0] OP_SEI = 3'd4;
    localparam logic [2:0] OP_CLV = 3'd5;
    localparam logic [2:0] OP_CLD = 3'd6;
    localparam logic [2:0] OP_SED = 3'd7;

    logic flag_n, flag_v, flag_d, flag_i, flag_z, flag_c;
    logic nxt_n, nxt_v, nxt_d, nxt_i, nxt_z, nxt_c;
    logic nmi_s, irq_s;
    logic nmi_prev, nmi_latch, i_poll;
    logic nmi_fell;

    // P bits 5/4 do not exist as storage; the pushed values come from constants
    logic unused_din;
    assign unused_din = ^din[5:4];

    generate
        if (NMI_SYNC) begin : g_sync
            logic [1:0] nmi_ff, irq_ff;
            // Two-stage synchronizers, preset high so reset never looks like an edge
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    nmi_ff <= 2'b11;
                    irq_ff <= 2'b11;
                end else begin
                    nmi_ff <= {nmi_ff[0], nmi_n};
                    irq_ff <= {irq_ff[0], irq_n};
                end
            end
            assign nmi_s = nmi_ff[1];
            assign irq_s = irq_ff[1];
        end else begin : g_direct
            assign nmi_s = nmi_n;
            assign irq_s = irq_n;
        end
    endgenerate

    // Next flag values: writes applied lowest priority first so later ones win per bit
    always_comb begin
        nxt_n = flag_n;
        nxt_v = flag_v;
        nxt_d = flag_d;
        nxt_i = flag_i;
        nxt_z = flag_z;
        nxt_c = flag_c;
        if (upd_nz) begin
            nxt_n = alu_sign;
            nxt_z = alu_zero;
        end
        if (upd_c) nxt_c = alu_carry;
        if (upd_v) nxt_v = alu_overflow;
        case (flag_op)
            OP_CLC:  nxt_c = 1'b0;
            OP_SEC:  nxt_c = 1'b1;
            OP_CLI:  nxt_i = 1'b0;
            OP_SEI:  nxt_i = 1'b1;
            OP_CLV:  nxt_v = 1'b0;
            OP_CLD:  nxt_d = 1'b0;
            OP_SED:  nxt_d = 1'b1;
            default: ;
        endcase
        // interrupt entry masks IRQ at the same level as an SEI
        if (intr_ack) nxt_i = 1'b1;
        if (bit_load) begin
            nxt_n = din[7];
            nxt_v = din[6];
            nxt_z = alu_zero;
        end
        if (plp_load) begin
            nxt_n = din[7];
            nxt_v = din[6];
            nxt_d = din[3];
            nxt_i = din[2];
            nxt_z = din[1];
            nxt_c = din[0];
        end
    end

    // Flag register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flag_n <= RESET_P[7];
            flag_v <= RESET_P[6];
            flag_d <= RESET_P[3];
            flag_i <= RESET_P[2];
            flag_z <= RESET_P[1];
            flag_c <= RESET_P[0];
        end else begin
            flag_n <= nxt_n;
            flag_v <= nxt_v;
            flag_d <= nxt_d;
            flag_i <= nxt_i;
            flag_z <= nxt_z;
            flag_c <= nxt_c;
        end
    end

    assign nmi_fell = nmi_prev & ~nmi_s;

    // NMI edge latch, boundary-sampled I mask and the pending-interrupt request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nmi_prev    <= 1'b1;
            nmi_latch   <= 1'b0;
            i_poll      <= 1'b1;
            int_pending <= 1'b0;
            int_is_nmi  <= 1'b0;
        end else begin
            nmi_prev <= nmi_s;
            // a fresh edge in the clearing cycle must not be lost
            if (nmi_fell)
                nmi_latch <= 1'b1;
            else if (intr_ack && int_is_nmi)
                nmi_latch <= 1'b0;
            if (sync) begin
                i_poll     <= flag_i;
                int_is_nmi <= nmi_latch;
            end
            if (intr_ack)
                int_pending <= 1'b0;
            else if (sync)
                int_pending <= nmi_latch | (~irq_s & ~i_poll);
        end
    end

    // Branch condition on the registered flags
    always_comb begin
        case (cond_sel)
            2'd0:    branch_taken = (flag_n == cond_val);
            2'd1:    branch_taken = (flag_v == cond_val);
            2'd2:    branch_taken = (flag_c == cond_val);
            default: branch_taken = (flag_z == cond_val);
        endcase
    end

    assign carry_in = flag_c;
    assign p_out    = {flag_n, flag_v, 1'b1, brk_flag, flag_d, flag_i, flag_z, flag_c};

endmodule

// File: tb/tb_status_flags.sv
// tb_status_flags: directed scenarios plus randomized traffic against a
// behavioural model of the 6502 status register and interrupt qualification.
module tb_status_flags;

    localparam logic [7:0] RESET_P = 8'h04;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       alu_carry = 0, alu_overflow = 0, alu_zero = 0, alu_sign = 0;
    logic       upd_nz = 0, upd_c = 0, upd_v = 0;
    logic [2:0] flag_op = 3'd0;
    logic       bit_load = 0, plp_load = 0;
    logic [7:0] din = 8'h00;
    logic       brk_flag = 1'b1;
    logic       sync = 0;
    logic [1:0] cond_sel = 2'd0;
    logic       cond_val = 0;
    logic       nmi_n = 1'b1, irq_n = 1'b1;
    logic       intr_ack = 0;
    logic       carry_in;
    logic [7:0] p_out;
    logic       branch_taken, int_pending, int_is_nmi;

    int n_tests = 0;
    int n_fail  = 0;

    // model state: P as a byte (bits 5/4 unused), interrupt bookkeeping
    logic [7:0] mp;
    logic       m_prev, m_latch, m_ipoll, m_pend, m_isnmi;
    bit         nq[$];
    bit         iq[$];

    status_flags #(.RESET_P(RESET_P), .NMI_SYNC(1'b1)) dut (
        .clk(clk), .reset_n(reset_n),
        .alu_carry(alu_carry), .alu_overflow(alu_overflow), .alu_zero(alu_zero), .alu_sign(alu_sign),
        .upd_nz(upd_nz), .upd_c(upd_c), .upd_v(upd_v), .flag_op(flag_op),
        .bit_load(bit_load), .plp_load(plp_load), .din(din), .brk_flag(brk_flag),
        .sync(sync), .cond_sel(cond_sel), .cond_val(cond_val),
        .nmi_n(nmi_n), .irq_n(irq_n), .intr_ack(intr_ack),
        .carry_in(carry_in), .p_out(p_out), .branch_taken(branch_taken),
        .int_pending(int_pending), .int_is_nmi(int_is_nmi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mp = RESET_P & 8'hCF;
        m_prev = 1'b1; m_latch = 1'b0; m_ipoll = 1'b1; m_pend = 1'b0; m_isnmi = 1'b0;
        nq = '{1'b1, 1'b1};
        iq = '{1'b1, 1'b1};
    endtask

    // one rising edge of the reference behaviour, using the inputs present at the edge
    task automatic model_step();
        logic [7:0] np;
        bit ns, is;
        np = mp;
        ns = nq.pop_front(); nq.push_back(nmi_n);
        is = iq.pop_front(); iq.push_back(irq_n);
        // each bit: highest-priority writer decides
        if (plp_load) np[7] = din[7]; else if (bit_load) np[7] = din[7]; else if (upd_nz) np[7] = alu_sign;
        if (plp_load) np[6] = din[6]; else if (bit_load) np[6] = din[6];
        else if (flag_op == 3'd5) np[6] = 1'b0; else if (upd_v) np[6] = alu_overflow;
        if (plp_load) np[3] = din[3]; else if (flag_op == 3'd6) np[3] = 1'b0; else if (flag_op == 3'd7) np[3] = 1'b1;
        if (plp_load) np[2] = din[2]; else if (intr_ack || flag_op == 3'd4) np[2] = 1'b1;
        else if (flag_op == 3'd3) np[2] = 1'b0;
        if (plp_load) np[1] = din[1]; else if (bit_load) np[1] = alu_zero; else if (upd_nz) np[1] = alu_zero;
        if (plp_load) np[0] = din[0]; else if (flag_op == 3'd1) np[0] = 1'b0;
        else if (flag_op == 3'd2) np[0] = 1'b1; else if (upd_c) np[0] = alu_carry;
        // interrupts (all right-hand sides are pre-edge values)
        if (intr_ack) m_pend = 1'b0;
        else if (sync) m_pend = m_latch | (!is && !m_ipoll);
        if (sync) begin
            m_isnmi = m_latch;
            m_ipoll = mp[2];
        end
        m_latch = (m_prev && !ns) || (m_latch && !(intr_ack && m_isnmi));
        m_prev  = ns;
        mp = np;
    endtask

    function automatic logic model_branch();
        logic f;
        case (cond_sel)
            2'd0: f = mp[7];
            2'd1: f = mp[6];
            2'd2: f = mp[0];
            default: f = mp[1];
        endcase
        return f == cond_val;
    endfunction

    task automatic check_all();
        chk("p_out", p_out, {mp[7:6], 1'b1, brk_flag, mp[3:0]});
        chk("carry_in", 8'(carry_in), 8'(mp[0]));
        chk("int_pending", 8'(int_pending), 8'(m_pend));
        chk("int_is_nmi", 8'(int_is_nmi), 8'(m_isnmi));
        chk("branch_taken", 8'(branch_taken), 8'(model_branch()));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    // called just after a negedge: clear all strobes
    task automatic idle();
        upd_nz = 0; upd_c = 0; upd_v = 0; flag_op = 3'd0;
        bit_load = 0; plp_load = 0; sync = 0; intr_ack = 0;
    endtask

    initial begin
        // power-up reset
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        chk("t1_por_p", p_out, 8'h34);
        chk("t1_por_carry", 8'(carry_in), 8'h00);
        chk("t1_por_pend", 8'(int_pending), 8'h00);
        @(negedge clk); reset_n = 1'b1; idle();
        tick();

        // test 2: ALU capture of C, N, Z
        @(negedge clk); idle();
        upd_c = 1; upd_nz = 1; alu_carry = 1; alu_sign = 1; alu_zero = 0;
        chk("t2_before_carry", 8'(carry_in), 8'h00);
        tick();
        chk("t2_carry", 8'(carry_in), 8'h01);
        chk("t2_n", 8'(p_out[7]), 8'h01);
        chk("t2_z", 8'(p_out[1]), 8'h00);

        // test 3: PLP beats CLC
        @(negedge clk); idle();
        plp_load = 1; din = 8'hFF; flag_op = 3'd1; brk_flag = 1;
        tick();
        chk("t3_p", p_out, 8'hFF);
        chk("t3_carry", 8'(carry_in), 8'h01);

        // test 1b: asynchronous reset mid-cycle discards state immediately
        #2 reset_n = 1'b0;
        #1;
        chk("t1_async_p", p_out, 8'h34);
        chk("t1_async_carry", 8'(carry_in), 8'h00);
        chk("t1_async_pend", 8'(int_pending), 8'h00);
        model_reset();
        @(negedge clk); reset_n = 1'b1; idle();
        tick();

        // test 4: CLI affects IRQ masking one instruction late
        @(negedge clk); idle(); irq_n = 0;
        tick();
        for (int i = 0; i < 3; i++) begin @(negedge clk); idle(); tick(); end
        @(negedge clk); idle(); flag_op = 3'd3;
        tick();
        @(negedge clk); idle(); sync = 1;
        tick();
        chk("t4_pend_first_sync", 8'(int_pending), 8'h00);
        @(negedge clk); idle(); sync = 1;
        tick();
        chk("t4_pend_second_sync", 8'(int_pending), 8'h01);
        chk("t4_is_nmi", 8'(int_is_nmi), 8'h00);
        @(negedge clk); idle(); intr_ack = 1;
        tick();
        chk("t4_ack_pend", 8'(int_pending), 8'h00);
        chk("t4_ack_i", 8'(p_out[2]), 8'h01);

        // test 5: held-low NMI with IRQ also asserted and unmasked
        @(negedge clk); idle(); flag_op = 3'd3;
        tick();
        @(negedge clk); idle(); sync = 1;
        tick();
        @(negedge clk); idle(); nmi_n = 0;
        tick();
        for (int i = 0; i < 4; i++) begin @(negedge clk); idle(); tick(); end
        @(negedge clk); idle(); sync = 1;
        tick();
        chk("t5_pend", 8'(int_pending), 8'h01);
        chk("t5_is_nmi", 8'(int_is_nmi), 8'h01);
        @(negedge clk); idle(); intr_ack = 1;
        tick();
        chk("t5_ack_pend", 8'(int_pending), 8'h00);
        chk("t5_ack_i", 8'(p_out[2]), 8'h01);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); idle(); sync = (i % 4 == 3);
            tick();
        end
        chk("t5_no_second_nmi", 8'(int_is_nmi), 8'h00);
        @(negedge clk); idle(); nmi_n = 1; irq_n = 1;
        tick();

        // test 6: branch on Z follows the registered flag
        @(negedge clk); idle(); plp_load = 1; din = 8'h02; cond_sel = 2'd3; cond_val = 1;
        tick();
        chk("t6_taken", 8'(branch_taken), 8'h01);
        @(negedge clk); idle(); plp_load = 1; din = 8'h00;
        #1 chk("t6_still_taken", 8'(branch_taken), 8'h01);
        tick();
        chk("t6_not_taken", 8'(branch_taken), 8'h00);
        chk("t6_p_z", 8'(p_out[1]), 8'h00);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            @(negedge clk); idle();
            alu_carry    = 1'($urandom); alu_overflow = 1'($urandom);
            alu_zero     = 1'($urandom); alu_sign     = 1'($urandom);
            upd_nz   = ($urandom_range(0, 2) == 0);
            upd_c    = ($urandom_range(0, 2) == 0);
            upd_v    = ($urandom_range(0, 2) == 0);
            flag_op  = ($urandom_range(0, 1) == 0) ? 3'($urandom) : 3'd0;
            bit_load = ($urandom_range(0, 5) == 0);
            plp_load = ($urandom_range(0, 6) == 0);
            din      = 8'($urandom);
            brk_flag = 1'($urandom);
            sync     = ($urandom_range(0, 3) == 0);
            cond_sel = 2'($urandom);
            cond_val = 1'($urandom);
            intr_ack = ($urandom_range(0, 9) == 0) && (flag_op != 3'd3);
            if ($urandom_range(0, 11) == 0) nmi_n = ~nmi_n;
            if ($urandom_range(0, 7) == 0) irq_n = ~irq_n;
            #1 chk("rand_branch_comb", 8'(branch_taken), 8'(model_branch()));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
